codificador_tr: RTL and testbench

Instruction encoder and issue buffer that builds 32-bit R-type instruction words (opcode 0, rs, rt, rd, shamt, funct) from field-level requests. It queues the words in a small FIFO and issues them, with sequential instruction-memory byte addresses, to a downstream writer or instruction register over a valid/ready handshake. It is the producer counterpart of the `Intrucciones_TR` field decoder: any word it emits decodes back to exactly the fields that were requested.

---
 rtl/codificador_tr_if.sv | 26 ++
 rtl/codificador_tr.sv | 97 +++++++++
 tb/tb_codificador_tr.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/codificador_tr_if.sv
// Request/issue bundle for the R-type encoder: field-level request in, encoded word out.
interface codificador_tr_if #(
   parameter int unsigned ADDR_W = 8
) ();
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [2:0]        in_op;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output in_valid, in_rs, in_rt, in_rd, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/codificador_tr.sv
// R-type instruction encoder with a small issue FIFO; words leave with sequential byte addresses.
module codificador_tr #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ADDR_W = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   codificador_tr_if.slave         bus,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]       mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              err_q, err_d;
   logic [5:0]        funct;
   logic              op_ok;
   logic [31:0]       word;
   logic              accept, push, pop;

   always_comb begin
      funct = 6'b000000;
      op_ok = 1'b1;
      case (bus.in_op)
         3'd0:    funct = 6'b100000;
         3'd1:    funct = 6'b100010;
         3'd2:    funct = 6'b100100;
         3'd3:    funct = 6'b100101;
         3'd4:    funct = 6'b101010;
         default: op_ok = 1'b0;
      endcase
   end

   assign word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, funct};

   // Handshake qualifiers come from count only; no path from in_valid/out_ready.
   assign bus.in_ready  = (count_q != CntW'(DEPTH));
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = instr_q;
   assign bus.out_addr  = addr_q;
   assign count         = count_q;
   assign err           = err_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && op_ok;
   assign pop    = bus.out_valid && bus.out_ready;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
      err_d  = err_q | (accept & ~op_ok);
      addr_d = pop ? addr_q + ADDR_W'(4) : addr_q;
      // Head register tracks the next head; the word being written may itself become the head.
      instr_d = instr_q;
      if (count_d != '0) begin
         instr_d = (push && (wr_ptr_q == rd_ptr_d)) ? word : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         instr_q  <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         err_q    <= err_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr_q == PtrW'(i))) begin
               mem_q[i] <= word;
            end
         end
      end
   end
endmodule

// File: tb/tb_codificador_tr.sv
// Scoreboard bench for codificador_tr: a reference encoder predicts every issued word and address.
module tb_codificador_tr;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW = 4;
   localparam logic [AW-1:0] BASE = 4'h0;

   logic clk;
   logic reset;
   logic [$clog2(DEPTH):0] count;
   logic err;

   codificador_tr_if #(.ADDR_W(AW)) bus ();

   codificador_tr #(
      .DEPTH(DEPTH),
      .ADDR_W(AW),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .count(count),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad = 0;

   logic [31:0] exp_q[$];
   logic [AW-1:0] m_addr;
   logic m_err;
   logic [31:0] m_last;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] encode(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [2:0] op);
      logic [5:0] f;
      case (op)
         3'd0:    f = 6'h20;
         3'd1:    f = 6'h22;
         3'd2:    f = 6'h24;
         3'd3:    f = 6'h25;
         default: f = 6'h2A;
      endcase
      return {6'b000000, rs, rt, rd, sh, f};
   endfunction

   // Checks state for the upcoming edge, then advances the model by that edge.
   always @(negedge clk) begin
      int sz;
      if (reset) begin
         exp_q.delete();
         m_addr = BASE;
         m_err  = 1'b0;
         m_last = '0;
      end
      sz = exp_q.size();
      check_eq("count", 32'(count), sz);
      check_eq("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
      check_eq("out_valid", 32'(bus.out_valid), 32'(sz > 0));
      check_eq("err", 32'(err), 32'(m_err));
      check_eq("out_addr", 32'(bus.out_addr), 32'(m_addr));
      if (sz > 0) check_eq("out_instr", bus.out_instr, exp_q[0]);
      else        check_eq("instr_hold", bus.out_instr, m_last);
      if (!reset) begin
         if (sz > 0 && bus.out_ready) begin
            m_last = exp_q.pop_front();
            m_addr = m_addr + AW'(4);
         end
         if (bus.in_valid && sz < DEPTH) begin
            if (bus.in_op < 3'd5)
               exp_q.push_back(encode(bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_op));
            else
               m_err = 1'b1;
         end
         if (exp_q.size() > 0) m_last = exp_q[0];
      end
   end

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [2:0] op);
      bus.in_rs    = rs;
      bus.in_rt    = rt;
      bus.in_rd    = rd;
      bus.in_shamt = sh;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [2:0] op);
      drive(rs, rt, rd, sh, op);
      wait_accept();
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 5'd0, 3'd0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Single ADD, then one issue pulse
      send(5'd10, 5'd11, 5'd12, 5'd0, 3'd0);
      check_eq("add_word", bus.out_instr, 32'h014B6020);
      check_eq("add_valid", 32'(bus.out_valid), 32'd1);
      check_eq("add_addr", 32'(bus.out_addr), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq("add_count", 32'(count), 32'd0);
      check_eq("add_addr4", 32'(bus.out_addr), 32'd4);

      // Back-to-back stream with consumer always ready; addresses wrap past 12
      bus.out_ready = 1'b1;
      for (int op = 1; op <= 4; op++) send(5'd10, 5'd11, 5'd12, 5'd0, 3'(op));
      send(5'd3, 5'd4, 5'd5, 5'd0, 3'd1);
      check_eq("sub_word", bus.out_instr, 32'h00642822);
      drain();

      // Fill to DEPTH with the consumer stalled; fifth request must wait
      for (int i = 0; i < 4; i++) send(5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i), 3'(i));
      drive(5'd31, 5'd30, 5'd29, 5'd28, 3'd4);
      repeat (3) @(posedge clk);
      #1;
      check_eq("full_ready", 32'(bus.in_ready), 32'd0);
      check_eq("full_count", 32'(count), 32'd4);
      bus.out_ready = 1'b1;
      wait_accept();
      drain();

      // Stall mid-stream
      for (int i = 0; i < 3; i++) send(5'(i + 7), 5'(i + 9), 5'(i + 11), 5'(i + 1), 3'(i + 1));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      drain();

      // Invalid op is consumed without a push and latches err
      send(5'd1, 5'd2, 5'd3, 5'd4, 3'd6);
      check_eq("inv_err", 32'(err), 32'd1);
      check_eq("inv_count", 32'(count), 32'd0);
      send(5'd7, 5'd8, 5'd9, 5'd5, 3'd2);
      check_eq("inv_next_word", bus.out_instr, 32'h00E84964);
      check_eq("inv_err_sticky", 32'(err), 32'd1);
      drain();

      // Asynchronous reset with words queued and err set
      for (int i = 0; i < 3; i++) send(5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 3'd3);
      send(5'd0, 5'd0, 5'd0, 5'd0, 3'd7);
      #2;
      reset = 1'b1;
      #1;
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst_addr", 32'(bus.out_addr), 32'(BASE));
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_instr", bus.out_instr, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(5'd3, 5'd4, 5'd5, 5'd0, 3'd1);
      check_eq("post_rst_word", bus.out_instr, 32'h00642822);
      check_eq("post_rst_addr", 32'(bus.out_addr), 32'(BASE));
      drain();

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
